// File: rtl/ppc_branch_unit_if.sv
// Issue/result handshake bundle for the PPC branch unit.
// The master side offers instructions and consumes redirects; the slave side is the unit.
interface ppc_branch_unit_if #(
    parameter int XLEN = 64
) ();

    // Issue channel
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_inst;
    logic [XLEN-1:0] in_pc;

    // Redirect channel
    logic            out_valid;
    logic            out_ready;
    logic            out_taken;
    logic [XLEN-1:0] out_target;
    logic            out_illegal;

    modport master (
        output in_valid,
        output in_inst,
        output in_pc,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_taken,
        input  out_target,
        input  out_illegal
    );

    modport slave (
        input  in_valid,
        input  in_inst,
        input  in_pc,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_taken,
        output out_target,
        output out_illegal
    );

endinterface

// File: rtl/ppc_branch_unit.sv
// Branch-resolution unit: owns LR/CTR/CR, resolves b/bc/bclr/bcctr and
// presents a registered redirect (taken, target) to fetch.
// Architectural bit numbering is big-endian (bit 0 = MSB); vectors here are
// declared [N-1:0], so architectural bit k of an N-bit field is vector bit N-1-k.
module ppc_branch_unit #(
    parameter int          XLEN      = 64,
    parameter logic [31:0] CR_RESET  = 32'h0,
    parameter bit          HAS_BCCTR = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    ppc_branch_unit_if.slave bus,
    input  logic            lr_wr_en,
    input  logic [XLEN-1:0] lr_wr_data,
    input  logic            ctr_wr_en,
    input  logic [XLEN-1:0] ctr_wr_data,
    input  logic            cr_wr_en,
    input  logic [2:0]      cr_wr_field,
    input  logic [3:0]      cr_wr_val,
    output logic [XLEN-1:0] lr,
    output logic [XLEN-1:0] ctr,
    output logic [31:0]     cr
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        K_ILL   = 3'd0,
        K_B     = 3'd1,
        K_BC    = 3'd2,
        K_BCLR  = 3'd3,
        K_BCCTR = 3'd4
    } kind_e;

    localparam logic [XLEN-1:0] INST_BYTES = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] ONE        = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0] ZERO       = {XLEN{1'b0}};

    state_e          stateReg;
    state_e          nextState;
    logic            accept;

    logic [XLEN-1:0] lrReg;
    logic [XLEN-1:0] ctrReg;
    logic [31:0]     crReg;
    logic [31:0]     crMerged;
    logic [4:0]      crBase;

    logic            outTakenReg;
    logic [XLEN-1:0] outTargetReg;
    logic            outIllegalReg;

    // Decoded instruction fields
    logic [5:0]      op;
    logic [4:0]      bo;
    logic [4:0]      bi;
    logic [9:0]      xop10;
    logic            aa;
    logic            lk;
    kind_e           kind;

    // BO bit meanings (architectural BO[0..3])
    logic            boIgnoreCond;
    logic            boCondVal;
    logic            boIgnoreCtr;
    logic            boCtrZero;

    logic [XLEN-1:0] liExt;
    logic [XLEN-1:0] bdExt;
    logic [XLEN-1:0] nia;
    logic [XLEN-1:0] ctrDec;
    logic            crBit;
    logic            ctrOk;
    logic            condOk;

    logic            resTaken;
    logic [XLEN-1:0] resTarget;
    logic            resIllegal;
    logic            resDecCtr;
    logic            resLink;

    assign accept = bus.in_valid & (stateReg == IDLE);

    // Field extraction and sign-extended displacements
    always_comb begin
        op           = bus.in_inst[31:26];
        bo           = bus.in_inst[25:21];
        bi           = bus.in_inst[20:16];
        xop10        = bus.in_inst[10:1];
        aa           = bus.in_inst[1];
        lk           = bus.in_inst[0];
        boIgnoreCond = bo[4];
        boCondVal    = bo[3];
        boIgnoreCtr  = bo[2];
        boCtrZero    = bo[1];
        liExt        = {{(XLEN-26){bus.in_inst[25]}}, bus.in_inst[25:2], 2'b00};
        bdExt        = {{(XLEN-16){bus.in_inst[15]}}, bus.in_inst[15:2], 2'b00};
    end

    // Classify the offered word; bcctr without BO[2] is treated as illegal
    always_comb begin
        kind = K_ILL;
        case (op)
            6'd18: kind = K_B;
            6'd16: kind = K_BC;
            6'd19: begin
                if (xop10 == 10'd16) begin
                    kind = K_BCLR;
                end else if ((xop10 == 10'd528) && (HAS_BCCTR == 1'b1) && boIgnoreCtr) begin
                    kind = K_BCCTR;
                end else begin
                    kind = K_ILL;
                end
            end
            default: kind = K_ILL;
        endcase
    end

    // Branch condition evaluation against LR/CTR/CR as held at the start of the cycle
    always_comb begin
        nia    = bus.in_pc + INST_BYTES;
        ctrDec = ctrReg - ONE;
        crBit  = crReg[5'd31 - bi];
        // the CTR test always looks at the decremented value
        ctrOk  = boIgnoreCtr | ((ctrDec != ZERO) ^ boCtrZero);
        condOk = boIgnoreCond | (crBit == boCondVal);
    end

    // Resolve taken/target and the side effects for the decoded form
    always_comb begin
        resTaken   = 1'b0;
        resTarget  = nia;
        resIllegal = 1'b0;
        resDecCtr  = 1'b0;
        case (kind)
            K_B: begin
                resTaken  = 1'b1;
                resTarget = aa ? liExt : (bus.in_pc + liExt);
            end
            K_BC: begin
                resTaken  = ctrOk & condOk;
                resDecCtr = ~boIgnoreCtr;
                if (ctrOk & condOk) begin
                    resTarget = aa ? bdExt : (bus.in_pc + bdExt);
                end else begin
                    resTarget = nia;
                end
            end
            K_BCLR: begin
                resTaken  = ctrOk & condOk;
                resDecCtr = ~boIgnoreCtr;
                if (ctrOk & condOk) begin
                    resTarget = {lrReg[XLEN-1:2], 2'b00};
                end else begin
                    resTarget = nia;
                end
            end
            K_BCCTR: begin
                resTaken = condOk;
                if (condOk) begin
                    resTarget = {ctrReg[XLEN-1:2], 2'b00};
                end else begin
                    resTarget = nia;
                end
            end
            default: begin
                resIllegal = 1'b1;
            end
        endcase
        resLink = lk & ~resIllegal;
    end

    // Handshake state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= nextState;
        end
    end

    // Next state: accept moves to RESP, consumer acceptance returns to IDLE
    always_comb begin
        nextState = stateReg;
        case (stateReg)
            IDLE: begin
                if (accept) begin
                    nextState = RESP;
                end else begin
                    nextState = IDLE;
                end
            end
            RESP: begin
                if (bus.out_ready) begin
                    nextState = IDLE;
                end else begin
                    nextState = RESP;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // Handshake outputs decoded from the state register
    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        case (stateReg)
            IDLE:    bus.in_ready  = 1'b1;
            RESP:    bus.out_valid = 1'b1;
            default: bus.in_ready  = 1'b0;
        endcase
    end

    // Capture the resolved branch at accept and hold it through backpressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outTakenReg   <= 1'b0;
            outTargetReg  <= ZERO;
            outIllegalReg <= 1'b0;
        end else if (accept) begin
            outTakenReg   <= resTaken;
            outTargetReg  <= resTarget;
            outIllegalReg <= resIllegal;
        end else begin
            outTakenReg   <= outTakenReg;
            outTargetReg  <= outTargetReg;
            outIllegalReg <= outIllegalReg;
        end
    end

    // LR: the instruction's own link update beats a same-cycle mtlr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lrReg <= ZERO;
        end else if (accept && resLink) begin
            lrReg <= nia;
        end else if (lr_wr_en) begin
            lrReg <= lr_wr_data;
        end else begin
            lrReg <= lrReg;
        end
    end

    // CTR: the instruction's own decrement beats a same-cycle mtctr
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrReg <= ZERO;
        end else if (accept && resDecCtr) begin
            ctrReg <= ctrDec;
        end else if (ctr_wr_en) begin
            ctrReg <= ctr_wr_data;
        end else begin
            ctrReg <= ctrReg;
        end
    end

    // Merge the addressed CR field; field f occupies architectural bits 4f..4f+3
    always_comb begin
        crBase   = 5'd28 - {cr_wr_field, 2'b00};
        crMerged = crReg;
        crMerged[crBase +: 4] = cr_wr_val;
    end

    // CR: only external field writes modify it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crReg <= CR_RESET;
        end else if (cr_wr_en) begin
            crReg <= crMerged;
        end else begin
            crReg <= crReg;
        end
    end

    assign bus.out_taken   = outTakenReg;
    assign bus.out_target  = outTargetReg;
    assign bus.out_illegal = outIllegalReg;
    assign lr              = lrReg;
    assign ctr             = ctrReg;
    assign cr              = crReg;

endmodule

// File: tb/tb_ppc_branch_unit.sv
// Self-checking bench for ppc_branch_unit: directed vector table, hand-written
// multi-cycle sequences and randomized instructions against a behavioural model.
module tb_ppc_branch_unit;

    localparam int XLEN = 64;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            lr_wr_en;
    logic [XLEN-1:0] lr_wr_data;
    logic            ctr_wr_en;
    logic [XLEN-1:0] ctr_wr_data;
    logic            cr_wr_en;
    logic [2:0]      cr_wr_field;
    logic [3:0]      cr_wr_val;
    logic [XLEN-1:0] lr;
    logic [XLEN-1:0] ctr;
    logic [31:0]     cr;

    ppc_branch_unit_if #(.XLEN(XLEN)) bif ();

    ppc_branch_unit #(.XLEN(XLEN), .CR_RESET(32'h0), .HAS_BCCTR(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bif),
        .lr_wr_en    (lr_wr_en),
        .lr_wr_data  (lr_wr_data),
        .ctr_wr_en   (ctr_wr_en),
        .ctr_wr_data (ctr_wr_data),
        .cr_wr_en    (cr_wr_en),
        .cr_wr_field (cr_wr_field),
        .cr_wr_val   (cr_wr_val),
        .lr          (lr),
        .ctr         (ctr),
        .cr          (cr)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // architectural state as the model believes it to be
    logic [63:0] mLr;
    logic [63:0] mCtr;
    logic [31:0] mCr;

    // DUT results captured at the first cycle of the last response
    logic        lastTaken;
    logic [63:0] lastTarget;
    logic        lastIll;

    typedef struct {
        logic [31:0] inst;
        logic [63:0] pc;
        logic [63:0] lrSet;
        logic [63:0] ctrSet;
        logic [3:0]  cr0;
        logic        expTaken;
        logic [63:0] expTarget;
        logic        expIll;
        logic [63:0] expLr;
        logic [63:0] expCtr;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crFieldSet(input logic [31:0] c, input logic [2:0] f, input logic [3:0] v);
        int sh;
        sh = 28 - 4 * int'(f);
        return (c & ~(32'hF << sh)) | ({28'h0, v} << sh);
    endfunction

    // Behavioural model of one branch, written from the ISA rules with plain arithmetic
    task automatic refModel(input logic [31:0] inst, input logic [63:0] pc, input logic [63:0] lrIn,
                            input logic [63:0] ctrIn, input logic [31:0] crIn,
                            output logic t, output logic [63:0] tgt, output logic ill,
                            output logic lrUpd, output logic ctrUpd,
                            output logic [63:0] lrNew, output logic [63:0] ctrNew);
        int unsigned op, bo, bi, xo, aa, lk;
        bit bo0, bo1, bo2, bo3, crb, ctrOk, condOk;
        longint sd;
        logic [63:0] nia, cnt;
        op  = (inst >> 26) & 32'd63;
        bo  = (inst >> 21) & 32'd31;
        bi  = (inst >> 16) & 32'd31;
        xo  = (inst >> 1) & 32'd1023;
        aa  = (inst >> 1) & 32'd1;
        lk  = inst & 32'd1;
        bo0 = ((bo >> 4) & 1) != 0;
        bo1 = ((bo >> 3) & 1) != 0;
        bo2 = ((bo >> 2) & 1) != 0;
        bo3 = ((bo >> 1) & 1) != 0;
        crb = ((crIn >> (31 - bi)) & 32'd1) != 0;
        nia = pc + 64'd4;
        t = 1'b0; ill = 1'b1; tgt = nia;
        lrUpd = 1'b0; ctrUpd = 1'b0; lrNew = lrIn; ctrNew = ctrIn;
        if (op == 18) begin
            ill = 1'b0;
            sd = longint'((inst >> 2) & 32'h00FF_FFFF);
            if (sd >= 64'sd8388608) sd = sd - 64'sd16777216;
            sd = sd * 4;
            t = 1'b1;
            tgt = (aa != 0) ? 64'(sd) : pc + 64'(sd);
        end else if (op == 16 || (op == 19 && xo == 16)) begin
            ill = 1'b0;
            cnt = ctrIn;
            if (!bo2) begin
                cnt = ctrIn - 64'd1;
                ctrUpd = 1'b1;
                ctrNew = cnt;
            end
            ctrOk  = bo2 || ((cnt != 64'd0) != bo3);
            condOk = bo0 || (crb == bo1);
            t = ctrOk && condOk;
            if (t) begin
                if (op == 16) begin
                    sd = longint'((inst >> 2) & 32'h0000_3FFF);
                    if (sd >= 64'sd8192) sd = sd - 64'sd16384;
                    sd = sd * 4;
                    tgt = (aa != 0) ? 64'(sd) : pc + 64'(sd);
                end else begin
                    tgt = lrIn & ~64'd3;
                end
            end
        end else if (op == 19 && xo == 528 && bo2) begin
            ill = 1'b0;
            t = bo0 || (crb == bo1);
            if (t) tgt = ctrIn & ~64'd3;
        end
        if (!ill && lk != 0) begin
            lrUpd = 1'b1;
            lrNew = nia;
        end
    endtask

    // One-cycle external write of LR, CTR and one CR field
    task automatic writeAll(input logic [63:0] lv, input logic [63:0] cv, input logic [2:0] f, input logic [3:0] v);
        lr_wr_en = 1'b1; lr_wr_data = lv;
        ctr_wr_en = 1'b1; ctr_wr_data = cv;
        cr_wr_en = 1'b1; cr_wr_field = f; cr_wr_val = v;
        @(posedge clk); #1;
        lr_wr_en = 1'b0; ctr_wr_en = 1'b0; cr_wr_en = 1'b0;
        mLr = lv; mCtr = cv; mCr = crFieldSet(mCr, f, v);
    endtask

    // Issue one instruction (optionally with same-cycle external writes), check the
    // response, hold it for 'stall' cycles of backpressure, then release it.
    task automatic issue(input logic [31:0] inst, input logic [63:0] pc,
                         input logic wl, input logic [63:0] wlv, input logic wc, input logic [63:0] wcv,
                         input logic wr, input logic [2:0] wrf, input logic [3:0] wrv, input int stall);
        logic eT, eI, lu, cu;
        logic [63:0] eTg, eL, eC;
        logic [31:0] eCr;
        refModel(inst, pc, mLr, mCtr, mCr, eT, eTg, eI, lu, cu, eL, eC);
        if (!lu && wl) eL = wlv;
        if (!cu && wc) eC = wcv;
        eCr = wr ? crFieldSet(mCr, wrf, wrv) : mCr;
        chk("in_ready_before_issue", {63'd0, bif.in_ready}, 64'd1);
        bif.in_valid = 1'b1; bif.in_inst = inst; bif.in_pc = pc;
        lr_wr_en = wl; lr_wr_data = wlv; ctr_wr_en = wc; ctr_wr_data = wcv;
        cr_wr_en = wr; cr_wr_field = wrf; cr_wr_val = wrv;
        @(posedge clk); #1;
        bif.in_valid = 1'b0; lr_wr_en = 1'b0; ctr_wr_en = 1'b0; cr_wr_en = 1'b0;
        bif.out_ready = (stall == 0);
        lastTaken = bif.out_taken; lastTarget = bif.out_target; lastIll = bif.out_illegal;
        chk("out_valid", {63'd0, bif.out_valid}, 64'd1);
        chk("out_taken", {63'd0, bif.out_taken}, {63'd0, eT});
        chk("out_target", bif.out_target, eTg);
        chk("out_illegal", {63'd0, bif.out_illegal}, {63'd0, eI});
        chk("lr_after", lr, eL);
        chk("ctr_after", ctr, eC);
        chk("cr_after", {32'd0, cr}, {32'd0, eCr});
        for (int s = 0; s < stall; s++) begin
            @(posedge clk); #1;
            chk("held_out_valid", {63'd0, bif.out_valid}, 64'd1);
            chk("held_out_target", bif.out_target, eTg);
            chk("held_in_ready", {63'd0, bif.in_ready}, 64'd0);
            if (s == stall - 1) bif.out_ready = 1'b1;
        end
        @(posedge clk); #1;
        chk("released_out_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("released_in_ready", {63'd0, bif.in_ready}, 64'd1);
        mLr = eL; mCtr = eC; mCr = eCr;
    endtask

    initial begin
        logic [31:0] r, inst;
        logic [63:0] pc;
        int k;

        vecs[0]  = '{32'h48000040, 64'h100,  64'h500,  64'h0,    4'h0, 1'b1, 64'h140,  1'b0, 64'h500,  64'h0};
        vecs[1]  = '{32'h48000041, 64'h100,  64'h500,  64'h0,    4'h0, 1'b1, 64'h140,  1'b0, 64'h104,  64'h0};
        vecs[2]  = '{32'h4200FFF8, 64'h200,  64'h500,  64'h3,    4'h0, 1'b1, 64'h1F8,  1'b0, 64'h500,  64'h2};
        vecs[3]  = '{32'h4200FFF8, 64'h200,  64'h500,  64'h1,    4'h0, 1'b0, 64'h204,  1'b0, 64'h500,  64'h0};
        vecs[4]  = '{32'h41820010, 64'h300,  64'h500,  64'h7,    4'h2, 1'b1, 64'h310,  1'b0, 64'h500,  64'h7};
        vecs[5]  = '{32'h41820010, 64'h300,  64'h500,  64'h7,    4'h0, 1'b0, 64'h304,  1'b0, 64'h500,  64'h7};
        vecs[6]  = '{32'h4E800020, 64'h400,  64'h1237, 64'h7,    4'h0, 1'b1, 64'h1234, 1'b0, 64'h1237, 64'h7};
        vecs[7]  = '{32'h4E800420, 64'h500,  64'h500,  64'h3000, 4'h0, 1'b1, 64'h3000, 1'b0, 64'h500,  64'h3000};
        vecs[8]  = '{32'h7C221A14, 64'h600,  64'h500,  64'h7,    4'h0, 1'b0, 64'h604,  1'b1, 64'h500,  64'h7};
        vecs[9]  = '{32'h4C000420, 64'h700,  64'h500,  64'h7,    4'h0, 1'b0, 64'h704,  1'b1, 64'h500,  64'h7};
        vecs[10] = '{32'h48000007, 64'h800,  64'h500,  64'h7,    4'h0, 1'b1, 64'h4,    1'b0, 64'h804,  64'h7};
        vecs[11] = '{32'h4BFFFFF0, 64'h1000, 64'h500,  64'h7,    4'h0, 1'b1, 64'hFF0,  1'b0, 64'h500,  64'h7};
        vecs[12] = '{32'h42400008, 64'h900,  64'h500,  64'h0,    4'h0, 1'b0, 64'h904,  1'b0, 64'h500,  64'hFFFF_FFFF_FFFF_FFFF};

        rst_n = 1'b0;
        bif.in_valid = 1'b0; bif.in_inst = 32'h0; bif.in_pc = 64'h0; bif.out_ready = 1'b1;
        lr_wr_en = 1'b0; lr_wr_data = 64'h0; ctr_wr_en = 1'b0; ctr_wr_data = 64'h0;
        cr_wr_en = 1'b0; cr_wr_field = 3'd0; cr_wr_val = 4'h0;
        mLr = 64'h0; mCtr = 64'h0; mCr = 32'h0;
        #12;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("reset_in_ready", {63'd0, bif.in_ready}, 64'd1);
        chk("reset_out_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("reset_out_target", bif.out_target, 64'd0);
        chk("reset_out_taken", {63'd0, bif.out_taken}, 64'd0);
        chk("reset_lr", lr, 64'd0);
        chk("reset_ctr", ctr, 64'd0);
        chk("reset_cr", {32'd0, cr}, 64'd0);

        // directed vector table
        for (int i = 0; i < 13; i++) begin
            writeAll(vecs[i].lrSet, vecs[i].ctrSet, 3'd0, vecs[i].cr0);
            issue(vecs[i].inst, vecs[i].pc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 3'd0, 4'h0, 0);
            chk($sformatf("vec%0d_taken", i), {63'd0, lastTaken}, {63'd0, vecs[i].expTaken});
            chk($sformatf("vec%0d_target", i), lastTarget, vecs[i].expTarget);
            chk($sformatf("vec%0d_illegal", i), {63'd0, lastIll}, {63'd0, vecs[i].expIll});
            chk($sformatf("vec%0d_lr", i), lr, vecs[i].expLr);
            chk($sformatf("vec%0d_ctr", i), ctr, vecs[i].expCtr);
        end

        // blrl with a same-cycle mtlr: target from old LR, link wins
        writeAll(64'h2000, 64'h5, 3'd0, 4'h0);
        issue(32'h4E800021, 64'h400, 1'b1, 64'h9999, 1'b0, 64'h0, 1'b0, 3'd0, 4'h0, 0);
        chk("blrl_target_old_lr", lastTarget, 64'h2000);
        chk("blrl_lr_link_wins", lr, 64'h404);
        // bdnz with a same-cycle mtctr: decrement wins
        issue(32'h4200FFF8, 64'h200, 1'b0, 64'h0, 1'b1, 64'h77, 1'b0, 3'd0, 4'h0, 0);
        chk("bdnz_ctr_dec_wins", ctr, 64'h4);
        // plain b with a same-cycle mtctr and CR write: external writes land
        issue(32'h48000040, 64'h100, 1'b0, 64'h0, 1'b1, 64'h55, 1'b1, 3'd7, 4'h9, 0);
        chk("b_ctr_ext_write", ctr, 64'h55);
        chk("b_cr_ext_write", {32'd0, cr}, 64'h9);

        // backpressure on an illegal word
        issue(32'h7C221A14, 64'h600, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 3'd0, 4'h0, 3);
        chk("bp_illegal", {63'd0, lastIll}, 64'd1);
        chk("bp_target", lastTarget, 64'h604);

        // asynchronous reset while a result is pending
        bif.in_valid = 1'b1; bif.in_inst = 32'h48000041; bif.in_pc = 64'h100;
        @(posedge clk); #1;
        bif.in_valid = 1'b0; bif.out_ready = 1'b0;
        chk("pre_reset_out_valid", {63'd0, bif.out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_out_valid", {63'd0, bif.out_valid}, 64'd0);
        chk("async_rst_out_taken", {63'd0, bif.out_taken}, 64'd0);
        chk("async_rst_out_target", bif.out_target, 64'd0);
        chk("async_rst_lr", lr, 64'd0);
        chk("async_rst_ctr", ctr, 64'd0);
        chk("async_rst_cr", {32'd0, cr}, 64'd0);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        bif.out_ready = 1'b1;
        chk("post_rst_in_ready", {63'd0, bif.in_ready}, 64'd1);
        chk("post_rst_out_valid", {63'd0, bif.out_valid}, 64'd0);
        mLr = 64'h0; mCtr = 64'h0; mCr = 32'h0;

        // randomized instructions against the model
        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 2) == 0) begin
                writeAll({$urandom, $urandom},
                         ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 2)) : {$urandom, $urandom},
                         3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            end
            r = $urandom;
            k = $urandom_range(0, 4);
            case (k)
                0:       inst = {6'd18, r[25:0]};
                1:       inst = {6'd16, r[25:0]};
                2:       inst = {6'd19, r[25:11], 10'd16, r[0]};
                3:       inst = {6'd19, r[25:11], 10'd528, r[0]};
                default: inst = r;
            endcase
            pc = {$urandom, $urandom};
            issue(inst, pc,
                  $urandom_range(0, 3) == 0, {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, {$urandom, $urandom},
                  $urandom_range(0, 3) == 0, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)),
                  $urandom_range(0, 2));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
